// File: rtl/debug_capture_spi_ctrl.sv
// debug_capture_spi_ctrl
// Buffers debug-instruction bytes from the core into a FIFO and drains them
// to an external host through a mode-0 (CPOL=0, CPHA=0) SPI slave link.
// Each frame starts with a status byte {overflow, count}. The host may send a
// flush command in that byte. Every later byte pops one FIFO entry.
//
// Ports:
//   i_clk, i_reset            system clock, asynchronous active-high reset
//   i_instr, i_capture        byte from the core and its push strobe
//   i_spi_sclk/csn/mosi       asynchronous SPI pins from the host
//   o_spi_miso                device->host data, 0 while CSN is high
//   o_count, o_empty          FIFO occupancy and empty flag
//   o_overflow                sticky flag for a dropped push
//   o_active                  synchronised CSN low
//   o_last_instr              last byte accepted into the FIFO
module debug_capture_spi_ctrl #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         ADDR_W      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] EMPTY_FILL  = 8'h00,
  parameter logic [7:0] CMD_FLUSH   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_instr,
  input  logic              i_capture,
  input  logic              i_spi_sclk,
  input  logic              i_spi_csn,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_active,
  output logic [7:0]        o_last_instr
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic sclk_prev, csn_prev;
  logic sclk_s, csn_s, mosi_s;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, do_push;

  logic [7:0] shreg, rx, rx_next;
  logic [2:0] bitcnt;
  logic       load_pend, cur_valid, hdr_ovf;
  logic       byte_done, flush, ovf_clear, pop;

  // Synchronisers start at the idle bus levels so that reset never produces
  // a spurious CSN or SCLK edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      csn_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_prev <= sclk_s;
      csn_prev  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign csn_fall  = ~csn_s & csn_prev;
  assign csn_rise  = csn_s & ~csn_prev;

  assign rx_next   = {rx[6:0], mosi_s};
  assign byte_done = sclk_rise & (bitcnt == 3'd7);
  assign full      = (o_count == (ADDR_W+1)'(FIFO_DEPTH));
  // A push while full is still accepted when the same cycle pops a slot free.
  // A flush discards any push in the same cycle.
  assign do_push   = i_capture & ~flush & (~full | pop);

  assign o_empty    = (o_count == '0);
  assign o_active   = ~csn_s;
  assign o_spi_miso = ~csn_s & shreg[7];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Frame sequencing: header byte first, then data bytes until CSN rises.
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    ovf_clear  = 1'b0;
    pop        = 1'b0;
    if (state != IDLE && csn_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (csn_fall) state_next = HDR;
        HDR: begin
          if (byte_done) begin
            if (rx_next == CMD_FLUSH) flush = 1'b1;
            else if (hdr_ovf)         ovf_clear = 1'b1;
            state_next = DATA;
          end
        end
        DATA: if (byte_done && cur_valid) pop = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_instr;
  end

  // FIFO bookkeeping. A new overflow beats a read-to-clear in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_count      <= '0;
      o_overflow   <= 1'b0;
      o_last_instr <= 8'h00;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr       <= wr_ptr + ADDR_W'(1);
        o_last_instr <= i_instr;
      end
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (do_push && !pop)      o_count <= o_count + (ADDR_W+1)'(1);
      else if (!do_push && pop) o_count <= o_count - (ADDR_W+1)'(1);
      if (i_capture && full && !pop) o_overflow <= 1'b1;
      else if (ovf_clear)            o_overflow <= 1'b0;
    end
  end

  // SPI shifter. Bits are received on SCLK rise. MISO advances on SCLK fall.
  // The byte after a completed one is loaded on the following fall, so a pop
  // on the 8th rise is already visible when the next head is peeked.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg     <= 8'h00;
      rx        <= 8'h00;
      bitcnt    <= 3'd0;
      load_pend <= 1'b0;
      cur_valid <= 1'b0;
      hdr_ovf   <= 1'b0;
    end else if (csn_rise) begin
      load_pend <= 1'b0;
      bitcnt    <= 3'd0;
    end else if (state == IDLE) begin
      if (csn_fall) begin
        shreg     <= {o_overflow, 7'(o_count)};
        hdr_ovf   <= o_overflow;
        bitcnt    <= 3'd0;
        load_pend <= 1'b0;
        cur_valid <= 1'b0;
      end
    end else if (sclk_rise) begin
      rx     <= rx_next;
      bitcnt <= bitcnt + 3'd1;
      if (bitcnt == 3'd7) load_pend <= 1'b1;
    end else if (sclk_fall) begin
      if (load_pend) begin
        shreg     <= o_empty ? EMPTY_FILL : mem[rd_ptr];
        cur_valid <= ~o_empty;
        load_pend <= 1'b0;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule
